// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit -- pipelined instruction memory for the RV32 fetch stage.
//
// Fetch requests are accepted over a valid/ready handshake; the addressed word
// reaches the response FIFO exactly READ_LAT cycles after acceptance. A program
// load port writes the array at any time (read-before-write on collisions),
// and flush discards every in-flight and queued response.
// Misaligned or out-of-range fetches return a NOP (addi x0,x0,0) with rsp_err.
//
// Optional feature: define IMEM_PARITY_EN to store one even-parity bit per word
// and add the sticky parity_err_o output.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/ready/addr  fetch request handshake and byte address
//   rsp_valid/ready       response handshake
//   rsp_data/addr/err     instruction word, its byte address, fault flag
//   flush                 drop all in-flight and queued responses
//   ld_we/addr/data       program-load write port (word index)
//   parity_err_o          sticky parity fault (IMEM_PARITY_EN only)

module imem_fetch_unit #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter              INIT_FILE  = "",
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [31:0]   rsp_addr,
  output logic          rsp_err,
  input  logic          flush,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
`ifdef IMEM_PARITY_EN
  ,
  output logic          parity_err_o
`endif
);

  localparam int unsigned FW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

  // Instruction array (not reset)
  logic [31:0] mem [DEPTH];
`ifdef IMEM_PARITY_EN
  logic        par_mem [DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
`ifdef IMEM_PARITY_EN
      par_mem[ld_addr] <= ^ld_data;
`endif
    end
  end

  // Request side: stage 0 is the combinational array read at the accept edge,
  // so a same-cycle load write is seen only by later fetches.
  logic          accept;
  logic          addr_fault;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          par_bad;
  rsp_t          s0_ent;

  always_comb begin
    word_idx   = req_addr[AW+1:2];
    addr_fault = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
    rd_word    = mem[word_idx];
    par_bad    = 1'b0;
`ifdef IMEM_PARITY_EN
    par_bad    = !addr_fault && (^{rd_word, par_mem[word_idx]});
`endif
    s0_ent.data = addr_fault ? NOP : rd_word;
    s0_ent.addr = req_addr;
    s0_ent.err  = addr_fault || par_bad;
  end

  assign accept = req_valid && req_ready;

  // Delay line: READ_LAT-1 registered stages after the stage-0 read.
  logic [READ_LAT-1:0] stg_vld;
  rsp_t                stg_ent [READ_LAT];

  assign stg_vld[0] = accept;
  assign stg_ent[0] = s0_ent;

  for (genvar g = 1; g < READ_LAT; g++) begin : g_stage
    logic vld_q, vld_d;
    rsp_t ent_q, ent_d;

    always_comb begin
      vld_d = stg_vld[g-1] && !flush;
      ent_d = stg_ent[g-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        ent_q <= '0;
      end else begin
        vld_q <= vld_d;
        ent_q <= ent_d;
      end
    end

    assign stg_vld[g] = vld_q;
    assign stg_ent[g] = ent_q;
  end

  // Occupancy = registered in-flight stages + FIFO entries; gating accepts on
  // it guarantees every in-flight word has a FIFO slot when it arrives.
  logic [CW:0] inflight;
  logic [CW:0] occ;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 1; i < READ_LAT; i++) inflight += (CW+1)'(stg_vld[i]);
  end

  // Response FIFO
  rsp_t          fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  rsp_t          head;

  assign occ       = {1'b0, cnt_q} + inflight;
  assign req_ready = !flush && (occ < (CW+1)'(FIFO_DEPTH));
  assign push      = stg_vld[READ_LAT-1];
  assign rsp_valid = (cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == FW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == FW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) fifo_mem[wr_ptr_q] <= stg_ent[READ_LAT-1];
  end

  // Outputs forced to zero whenever no response is held
  assign head     = fifo_mem[rd_ptr_q];
  assign rsp_data = rsp_valid ? head.data : '0;
  assign rsp_addr = rsp_valid ? head.addr : '0;
  assign rsp_err  = rsp_valid ? head.err  : 1'b0;

`ifdef IMEM_PARITY_EN
  logic parity_err_q, parity_err_d;

  always_comb begin
    parity_err_d = parity_err_q || (accept && par_bad);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.

module tb_imem_fetch_unit;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 2;
  localparam int unsigned FD    = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_data, rsp_addr;
  logic          rsp_err;
  logic          flush;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  imem_fetch_unit #(
    .DEPTH(DEPTH),
    .READ_LAT(LAT),
    .FIFO_DEPTH(FD),
    .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .flush(flush), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned acc_cnt  = 0;
  int unsigned edge_n   = 0;

  // Reference model: word array, pending reads (with due edge), response queue
  typedef struct {
    logic [31:0] d;
    logic [31:0] a;
    logic        e;
    int unsigned due;
  } item_t;

  logic [31:0] mem_m [DEPTH];
  item_t       pend [$];
  item_t       fq   [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic item_t model_fetch(input logic [31:0] a);
    item_t it;
    bit    fault;
    fault = (a % 4 != 0) || ((a / 4) >= DEPTH);
    it.a  = a;
    it.e  = fault;
    it.d  = fault ? 32'h0000_0013 : mem_m[a / 4];
    it.due = 0;
    return it;
  endfunction

  // One clock: check outputs against the model, advance the model across the edge.
  task automatic cycle();
    bit    exp_rdy, exp_vld, acc, pop;
    item_t it;
    #1;
    exp_rdy = !flush && ((pend.size() + fq.size()) < FD);
    exp_vld = (fq.size() != 0);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (exp_vld) begin
      check("rsp_data", rsp_data, fq[0].d);
      check("rsp_addr", rsp_addr, fq[0].a);
      check("rsp_err",  32'(rsp_err), 32'(fq[0].e));
    end
    acc = req_valid && exp_rdy;
    pop = exp_vld && rsp_ready;
    if (acc) begin
      it     = model_fetch(req_addr);
      it.due = edge_n + LAT - 1;
      acc_cnt++;
    end
    @(posedge clk);
    if (flush) begin
      pend.delete();
      fq.delete();
    end else begin
      if (pop) void'(fq.pop_front());
      if (acc) pend.push_back(it);
      while (pend.size() != 0 && pend[0].due <= edge_n) fq.push_back(pend.pop_front());
    end
    if (ld_we) mem_m[ld_addr] = ld_data;
    edge_n++;
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    flush     = 1'b0;
    ld_we     = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic drain(input int unsigned n);
    idle();
    rsp_ready = 1'b1;
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  logic [31:0] prog [3];
  int unsigned r;

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00a0_0113;
    prog[2] = 32'h0020_81b3;

    rst_n = 1'b0; rsp_ready = 1'b0; req_addr = '0; ld_addr = '0; ld_data = '0;
    idle();
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_addr",  rsp_addr, 32'd0);
    check("rst_rsp_err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program load: three known words, rest random
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ld_we   = 1'b1;
      ld_addr = AW'(i);
      ld_data = (i < 3) ? prog[i] : $urandom;
      cycle();
    end
    idle();

    // Back-to-back fetches at full rate
    rsp_ready = 1'b1;
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    drain(4);

    // Back-pressure: only FD requests accepted while rsp_ready is low
    rsp_ready = 1'b0;
    acc_cnt   = 0;
    req_valid = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      req_addr = 32'(i * 4 + 12);
      cycle();
    end
    check("bp_accepts", acc_cnt, FD);
    drain(8);

    // Address faults
    fetch(32'h2); fetch(32'h100);
    drain(4);

    // Load-write collides with a fetch of the same word
    ld_we = 1'b1; ld_addr = AW'(3); ld_data = 32'hDEAD_BEEF;
    fetch(32'hC);
    ld_we = 1'b0;
    fetch(32'hC);
    drain(4);

    // Flush with three requests in flight
    rsp_ready = 1'b0;
    fetch(32'h10); fetch(32'h14); fetch(32'h18);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h1C;
    cycle();
    flush = 1'b0; req_valid = 1'b0;
    rsp_ready = 1'b1;
    fetch(32'h4);
    drain(4);

    // Asynchronous reset mid-stream
    rsp_ready = 1'b0;
    fetch(32'h0); fetch(32'h8); fetch(32'hC);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_rsp_data",  rsp_data, 32'd0);
    pend.delete();
    fq.delete();
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    fetch(32'hC); fetch(32'h4);
    drain(4);

    // Random traffic
    for (int unsigned n = 0; n < 1500; n++) begin
      req_valid = ($urandom % 4) != 0;
      r = $urandom % 10;
      if (r < 7)       req_addr = 32'(($urandom % DEPTH) * 4);
      else if (r == 7) req_addr = 32'(($urandom % DEPTH) * 4 + 1 + ($urandom % 3));
      else if (r == 8) req_addr = 32'(DEPTH * 4 + ($urandom % 256) * 4);
      else             req_addr = $urandom;
      rsp_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 40) == 0;
      ld_we     = ($urandom % 8) == 0;
      ld_addr   = AW'($urandom % DEPTH);
      ld_data   = $urandom;
      cycle();
    end
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
